// File: rtl/par_rr_arbiter_pkg.sv
// Shared definitions for the round-robin parity-check scheduler:
// parity modes, default sizing and the per-stage pipeline state type.
package par_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_DW   = 3;
  localparam int unsigned DEF_CNTW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } stage_st_e;

endpackage

// File: rtl/par_rr_arbiter_if.sv
// Request/checker/response bundle between the front-ends, the scheduler
// and the shared checker. master = front-ends + checker, slave = scheduler.
interface par_rr_arbiter_if
  import par_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned DW   = DEF_DW
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_mode;
  logic [NREQ-1:0]    req_ready;

  logic               chk_valid;
  logic [DW-1:0]      chk_data;
  logic               chk_mode;
  logic               chk_parity_ok;

  logic [NREQ-1:0]    rsp_valid;
  logic               rsp_ok;

  modport master (
    output req_valid, req_data, req_mode, chk_parity_ok,
    input  req_ready, chk_valid, chk_data, chk_mode, rsp_valid, rsp_ok
  );

  modport slave (
    input  req_valid, req_data, req_mode, chk_parity_ok,
    output req_ready, chk_valid, chk_data, chk_mode, rsp_valid, rsp_ok
  );
endinterface

// File: rtl/par_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at NREQ-1, returned as a one-hot grant plus its index.
module rr_grant #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [PW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = PW'((32'(ptr) + i) % NREQ);
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/par_rr_arbiter.sv
// Round-robin scheduler sharing one parity checker between NREQ requesters;
// tags each issue through the checker latency and keeps saturating error counts.
module par_rr_arbiter
  import par_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic                 clk,
  input  logic                 rst,
  par_rr_arbiter_if.slave      bus,
  input  logic                 hold,
  input  logic                 clr_cnt,
  output logic [NREQ*CNTW-1:0] err_cnt,
  output logic                 busy
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            xfer;

  stage_st_e       iss_st;
  stage_st_e       rsp_st;
  logic [PW-1:0]   tag1;
  logic [DW-1:0]   chk_data_q;
  logic            chk_mode_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [CNTW-1:0] cnt [NREQ];

  rr_grant #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_grant (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign xfer          = grant_any && !hold;
  assign bus.req_ready = hold ? '0 : grant;

  // Issue and response stages each advance every cycle, so back-to-back
  // transfers simply occupy both stages at once with no stall logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      iss_st      <= ST_IDLE;
      rsp_st      <= ST_IDLE;
      tag1        <= '0;
      chk_data_q  <= '0;
      chk_mode_q  <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      if (xfer) begin
        ptr        <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
        iss_st     <= ST_ISSUE;
        tag1       <= grant_idx;
        chk_data_q <= bus.req_data[grant_idx*DW +: DW];
        chk_mode_q <= bus.req_mode[grant_idx];
      end else begin
        iss_st     <= ST_IDLE;
      end

      if (iss_st == ST_ISSUE) begin
        rsp_st      <= ST_RESP;
        rsp_valid_q <= NREQ'(1) << tag1;
      end else begin
        rsp_st      <= ST_IDLE;
        rsp_valid_q <= '0;
      end
    end
  end

  assign bus.chk_valid = (iss_st == ST_ISSUE);
  assign bus.chk_data  = chk_data_q;
  assign bus.chk_mode  = chk_mode_q;
  assign bus.rsp_valid = rsp_valid_q;
  // The checker registers its result, so it lines up with the response stage.
  assign bus.rsp_ok    = (rsp_st == ST_RESP) && bus.chk_parity_ok;
  assign busy          = (iss_st == ST_ISSUE) || (rsp_st == ST_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (clr_cnt)
          cnt[i] <= '0;
        else if (rsp_valid_q[i] && !bus.chk_parity_ok && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNTW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
    assign err_cnt[gi*CNTW +: CNTW] = cnt[gi];
  end
endmodule

// File: tb/tb_par_rr_arbiter.sv
// Directed bench for par_rr_arbiter with a cycle-level reference model
// and a registered parity checker stand-in.
module tb_par_rr_arbiter;
  import par_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 3;
  localparam int unsigned CNTW = 2;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic                 clk;
  logic                 rst;
  logic                 hold;
  logic                 clr_cnt;
  logic [NREQ*CNTW-1:0] err_cnt;
  logic                 busy;

  int n_assert = 0;
  int n_fail   = 0;

  par_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  par_rr_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .CNTW (CNTW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .hold    (hold),
    .clr_cnt (clr_cnt),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared checker stand-in: registered result, garbage-high when idle.
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.chk_parity_ok <= 1'b0;
    else if (bus.chk_valid) bus.chk_parity_ok <= ((^bus.chk_data) == bus.chk_mode);
    else bus.chk_parity_ok <= 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: issued requests kept as plain records moving through
  // two slots; grant chosen by scanning from the pointer.
  int   m_ptr;
  bit   m_iss_v, m_rsp_v;
  int   m_iss_g, m_rsp_g;
  int   m_iss_d, m_rsp_d;
  bit   m_iss_m, m_rsp_m;
  int   m_cnt [NREQ];

  always @(negedge clk) begin
    int g;
    bit ok;
    logic [NREQ*CNTW-1:0] e;
    e = '0;
    for (int i = 0; i < NREQ; i++) e[i*CNTW +: CNTW] = CNTW'(m_cnt[i]);
    if (!rst) begin
      m_ptr = 0; m_iss_v = 0; m_rsp_v = 0;
      m_iss_g = 0; m_rsp_g = 0; m_iss_d = 0; m_rsp_d = 0; m_iss_m = 0; m_rsp_m = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      check("rst_chk_valid", 32'(bus.chk_valid), 0);
      check("rst_chk_data",  32'(bus.chk_data), 0);
      check("rst_chk_mode",  32'(bus.chk_mode), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_ok",    32'(bus.rsp_ok), 0);
      check("rst_err_cnt",   32'(err_cnt), 0);
      check("rst_busy",      32'(busy), 0);
    end else begin
      g = -1;
      if (!hold)
        for (int i = 0; i < NREQ; i++)
          if (g < 0 && bus.req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      ok = m_rsp_v && (($countones(m_rsp_d) % 2) == int'(m_rsp_m));

      check("m_req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      check("m_chk_valid", 32'(bus.chk_valid), 32'(m_iss_v));
      if (m_iss_v) begin
        check("m_chk_data", 32'(bus.chk_data), 32'(m_iss_d));
        check("m_chk_mode", 32'(bus.chk_mode), 32'(m_iss_m));
      end
      check("m_rsp_valid", 32'(bus.rsp_valid), m_rsp_v ? (32'd1 << m_rsp_g) : 32'd0);
      check("m_rsp_ok",    32'(bus.rsp_ok), 32'(ok));
      check("m_busy",      32'(busy), 32'(m_iss_v || m_rsp_v));
      check("m_err_cnt",   32'(err_cnt), 32'(e));

      if (m_rsp_v && !ok && m_cnt[m_rsp_g] < CMAX) m_cnt[m_rsp_g]++;
      if (clr_cnt) for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      m_rsp_v = m_iss_v; m_rsp_g = m_iss_g; m_rsp_d = m_iss_d; m_rsp_m = m_iss_m;
      m_iss_v = (g >= 0);
      if (g >= 0) begin
        m_iss_g = g;
        m_iss_d = int'(bus.req_data[g*DW +: DW]);
        m_iss_m = bus.req_mode[g];
        m_ptr   = (g + 1) % NREQ;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hold = 1'b0; clr_cnt = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_mode = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // Reset mid-flight
    bus.req_valid = 4'b0010; bus.req_data[3 +: 3] = 3'b011; bus.req_mode[1] = PAR_EVEN;
    cyc();
    check("mid_chk_valid_pre", 32'(bus.chk_valid), 1);
    bus.req_valid = '0; rst = 1'b0; #1;
    check("mid_chk_valid", 32'(bus.chk_valid), 0);
    check("mid_busy", 32'(busy), 0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (3) cyc();
    check("mid_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mid_err_cnt", 32'(err_cnt), 0);

    // Round-robin fairness
    bus.req_valid = 4'b1111; bus.req_data = 12'b001_001_001_001; bus.req_mode = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), 32'd1 << (k % 4));
      if (k >= 2) begin
        check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1 << ((k - 2) % 4));
        check("rr_rsp_ok", 32'(bus.rsp_ok), 0);
      end
      cyc();
    end
    bus.req_valid = '0;
    repeat (3) cyc();
    check("rr_err_cnt", 32'(err_cnt), 32'h0000_00AA);
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0; #1;
    check("clr_err_cnt", 32'(err_cnt), 0);

    // Parity rule on req2
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      bus.req_data[6 +: 3] = 3'(k);
      bus.req_mode[2] = (k % 2 == 1) ? PAR_ODD : PAR_EVEN;
      cyc();
    end
    bus.req_valid = '0;
    repeat (2) cyc();
    bus.req_data[6 +: 3] = 3'b110; bus.req_mode[2] = PAR_EVEN; bus.req_valid = 4'b0100;
    cyc(); bus.req_valid = '0; cyc(); #1;
    check("par_110_even_vld", 32'(bus.rsp_valid), 32'b0100);
    check("par_110_even_ok", 32'(bus.rsp_ok), 1);
    bus.req_mode[2] = PAR_ODD; bus.req_valid = 4'b0100;
    cyc(); bus.req_valid = '0; cyc(); #1;
    check("par_110_odd_ok", 32'(bus.rsp_ok), 0);
    repeat (2) cyc();
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;

    // Hold mid-stream
    bus.req_data[0 +: 3] = 3'b111; bus.req_mode[0] = PAR_ODD; bus.req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1 check("hold_pre_grant", 32'(bus.req_ready), 32'b0001);
      cyc();
    end
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      #1 check("hold_ready", 32'(bus.req_ready), 0);
      if (h == 1) check("hold_drain_rsp", 32'(bus.rsp_valid), 32'b0001);
      if (h == 2) begin
        check("hold_drain_idle", 32'(bus.rsp_valid), 0);
        check("hold_busy", 32'(busy), 0);
      end
      cyc();
    end
    hold = 1'b0; bus.req_valid = 4'b1111; #1;
    check("hold_resume_ptr", 32'(bus.req_ready), 32'b0010);
    cyc(); bus.req_valid = '0;
    repeat (3) cyc();
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;

    // Saturation then clear-vs-error on req3
    bus.req_data[9 +: 3] = 3'b001; bus.req_mode[3] = PAR_EVEN; bus.req_valid = 4'b1000;
    repeat (5) cyc();
    bus.req_valid = '0;
    repeat (3) cyc();
    check("sat_err_cnt3", 32'(err_cnt[7:6]), 3);
    clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
    bus.req_valid = 4'b1000; cyc(); bus.req_valid = '0; cyc();
    clr_cnt = 1'b1; #1;
    check("clr_coinc_rsp", 32'(bus.rsp_valid), 32'b1000);
    check("clr_coinc_ok", 32'(bus.rsp_ok), 0);
    cyc(); clr_cnt = 1'b0; #1;
    check("clr_wins", 32'(err_cnt[7:6]), 0);
    cyc();

    // Back-to-back req0 then req3
    bus.req_data[0 +: 3] = 3'b000; bus.req_mode[0] = PAR_EVEN;
    bus.req_data[9 +: 3] = 3'b111; bus.req_mode[3] = PAR_ODD;
    bus.req_valid = 4'b0001; #1;
    check("b2b_grant0", 32'(bus.req_ready), 32'b0001);
    cyc(); bus.req_valid = 4'b1000; #1;
    check("b2b_grant3", 32'(bus.req_ready), 32'b1000);
    check("b2b_chk1", 32'(bus.chk_valid), 1);
    check("b2b_busy1", 32'(busy), 1);
    cyc(); bus.req_valid = '0; #1;
    check("b2b_chk2", 32'(bus.chk_valid), 1);
    check("b2b_rsp0", 32'(bus.rsp_valid), 32'b0001);
    check("b2b_ok0", 32'(bus.rsp_ok), 1);
    check("b2b_busy2", 32'(busy), 1);
    cyc();
    check("b2b_chk3", 32'(bus.chk_valid), 0);
    check("b2b_rsp3", 32'(bus.rsp_valid), 32'b1000);
    check("b2b_ok3", 32'(bus.rsp_ok), 1);
    check("b2b_busy3", 32'(busy), 1);
    cyc();
    check("b2b_busy4", 32'(busy), 0);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
